spi_cmd_sequencer: RTL and testbench
====================================

// Module: spi_cmd_sequencer
// PURPOSE
//  Upstream feeder for the SPI master top level. Buffers 32-bit host command words (control 0x8xxx_xxxx,
//  data 0x4xxx_xxxx) and replays them as ep_dataout + 1-cycle trigger pulses with fixed spacing.
//  Waits for the master's hostinterrupt after each data word, replacing host-timed trigger sequencing.
// PARAMETERS
//  DEPTH          16    command FIFO depth in words; power of 2, >= 2
//  GAP_CYCLES     4     idle cycles after every trigger pulse before the next action; >= 1
//  TIMEOUT_CYCLES 4096  max WAIT_DONE cycles (used only with SPI_SEQ_TIMEOUT_EN)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous, active-high reset
//  cmd_data      in   32  host command word
//  cmd_valid     in   1   cmd_data valid; word accepted on cycle with cmd_valid & cmd_ready
//  cmd_ready     out  1   FIFO not full
//  go            in   1   1-cycle pulse: start replaying FIFO contents
//  flush         in   1   1-cycle pulse: empty FIFO, abort run
//  ep_dataout    out  32  word to SPI master; held stable between ISSUE cycles
//  trigger       out  1   1-cycle strobe to SPI master, coincident with new ep_dataout
//  hostinterrupt in   1   SPI master transfer-complete pulse
//  busy          out  1   high in every state except IDLE
//  done          out  1   1-cycle pulse when a run ends (FIFO drained or timeout)
//  fifo_count    out  $clog2(DEPTH)+1  words held
//  bad_cmd       out  1   sticky: a word with bits[31:30]=00/11 was dropped; cleared by rst or go
//  timeout       out  1   sticky: WAIT_DONE expired; cleared by rst or go
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, ep_dataout=0, trigger=0, busy=0, done=0, bad_cmd=0, timeout=0, cmd_ready=1.
//  Word class by bits[31:30]: 10=CTRL, 01=DATA, 00/11=reserved.
//  States: IDLE, FETCH, ISSUE, GAP, WAIT_DONE.
//   IDLE:  go -> FETCH (clears bad_cmd, timeout). go while busy ignored.
//   FETCH: FIFO empty -> IDLE + done pulse; reserved word -> pop, set bad_cmd, stay FETCH;
//          else pop, latch word into ep_dataout -> ISSUE.
//   ISSUE: trigger=1 exactly this cycle -> GAP (counter loaded GAP_CYCLES).
//   GAP:   count to 0; then CTRL -> FETCH, DATA -> WAIT_DONE.
//   WAIT_DONE: hostinterrupt=1 sampled -> FETCH. hostinterrupt during ISSUE/GAP is latched and satisfies it.
//  Latency: go to first trigger = 2 cycles; CTRL word-to-word trigger spacing = GAP_CYCLES+2.
//  Push accepted in any state, including during a run (appended words are replayed in the same run).
//  Full: cmd_ready=0, no pass-through; push+pop in same cycle when not full: count unchanged.
//  flush: any state -> IDLE, FIFO emptied, trigger forced 0, no done pulse; flush wins over push/go same cycle.
//  rst mid-run: same as reset values; in-flight SPI transfer is abandoned (master reset separately).
//  Pointers wrap modulo DEPTH; fifo_count saturates neither way (full/empty guard push/pop).
// CONFIGURATION
//  SPI_SEQ_TIMEOUT_EN defined: WAIT_DONE counts cycles; reaching TIMEOUT_CYCLES sets timeout, flushes FIFO,
//   -> IDLE with done pulse.
//  Not defined: WAIT_DONE waits indefinitely; timeout tied 0; TIMEOUT_CYCLES unused.
// STRUCTURE
//  Package spi_seq_pkg: state encodings, class codes (CLS_CTRL=2'b10, CLS_DATA=2'b01), class field bit range.
//  Sub-module spi_seq_fifo: synchronous DEPTH x 32 FIFO with push/pop/clear/count, first-word visible
//   on dout while not empty; sequencer holds FSM, gap counter, timeout counter, flags.
// TESTING
//  1) Push 80000051,40000001,80000001,40008AA5; go; pulse hostinterrupt 20 cycles after each DATA trigger
//     -> 4 triggers, ep_dataout in order, CTRL spacing 6 cycles, done once, fifo_count=0.
//  2) Push 16 words -> cmd_ready=0, 17th push ignored, fifo_count=16; go -> all 16 issued in order.
//  3) Push 00001234 between two CTRL words -> it is never driven, bad_cmd=1, other 2 triggers occur.
//  4) Push 40003710, go, no hostinterrupt -> busy stays 1; with SPI_SEQ_TIMEOUT_EN, after 4096 cycles
//     timeout=1, done pulse, IDLE.
//  5) Push 3 DATA words, go, flush during WAIT_DONE -> IDLE next cycle, fifo_count=0, no done, no further trigger.
//  6) rst asserted during GAP -> next cycle all outputs at reset values; go after rst with empty FIFO ->
//     done pulse 1 cycle later, zero triggers.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI command sequencer: FSM state encoding, command-word class codes
// and the bit range of the class field.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_GAP       = 3'd3,
    ST_WAIT_DONE = 3'd4
  } seq_state_e;

  localparam logic [1:0] CLS_CTRL = 2'b10;
  localparam logic [1:0] CLS_DATA = 2'b01;
  localparam int         CLS_MSB  = 31;
  localparam int         CLS_LSB  = 30;

  function automatic logic [1:0] word_class(input logic [31:0] word);
    return word[CLS_MSB:CLS_LSB];
  endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous DEPTH x WIDTH command FIFO; the oldest word is visible on dout while not empty.
// clear has priority over push and pop.
module spi_seq_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // NOTE: storage carries no reset; only the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Replays buffered host command words to the SPI master as ep_dataout + trigger strobes.
// Optional WAIT_DONE watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            cmd_data,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   go,
  input  logic                   flush,
  output logic [31:0]            ep_dataout,
  output logic                   trigger,
  input  logic                   hostinterrupt,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   bad_cmd,
  output logic                   timeout
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end
  if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("GAP_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  seq_state_e  state_q;
  logic [31:0] ep_q;
  logic        trigger_q, done_q, bad_cmd_q, is_data_q, hi_pend_q;
  logic [GW-1:0] gap_q;

  logic [31:0] fifo_dout;
  logic        fifo_full, fifo_empty, fifo_pop, fifo_clear, timeout_fire, hi_seen;
  logic [1:0]  head_cls;

  assign head_cls   = word_class(fifo_dout);
  assign hi_seen    = hostinterrupt || hi_pend_q;
  assign fifo_pop   = (state_q == ST_FETCH) && !fifo_empty;
  assign fifo_clear = flush || timeout_fire;

  spi_seq_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (fifo_clear),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .din   (cmd_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;
  logic          timeout_q;

  assign timeout_fire = (state_q == ST_WAIT_DONE) && !hi_seen && !flush &&
                        (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == ST_WAIT_DONE && !flush) ? to_cnt_q + TW'(1) : '0;
      if (!flush && state_q == ST_IDLE && go) timeout_q <= 1'b0;
      else if (timeout_fire)                  timeout_q <= 1'b1;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout_fire = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ep_q      <= '0;
      trigger_q <= 1'b0;
      done_q    <= 1'b0;
      bad_cmd_q <= 1'b0;
      is_data_q <= 1'b0;
      hi_pend_q <= 1'b0;
      gap_q     <= '0;
    end else begin
      trigger_q <= 1'b0;
      done_q    <= 1'b0;
      if (flush) begin
        state_q   <= ST_IDLE;
        hi_pend_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (go) begin
              state_q   <= ST_FETCH;
              bad_cmd_q <= 1'b0;
            end
          end
          ST_FETCH: begin
            hi_pend_q <= 1'b0;
            if (fifo_empty) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else if (head_cls != CLS_CTRL && head_cls != CLS_DATA) begin
              bad_cmd_q <= 1'b1;
            end else begin
              ep_q      <= fifo_dout;
              is_data_q <= (head_cls == CLS_DATA);
              trigger_q <= 1'b1;
              state_q   <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (hostinterrupt) hi_pend_q <= 1'b1;
            gap_q   <= GW'(GAP_CYCLES - 1);
            state_q <= ST_GAP;
          end
          ST_GAP: begin
            // A fast master may finish while we are still spacing; remember it.
            if (hostinterrupt) hi_pend_q <= 1'b1;
            if (gap_q == '0) state_q <= is_data_q ? ST_WAIT_DONE : ST_FETCH;
            else             gap_q   <= gap_q - GW'(1);
          end
          ST_WAIT_DONE: begin
            if (hi_seen) begin
              state_q   <= ST_FETCH;
              hi_pend_q <= 1'b0;
            end else if (timeout_fire) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready  = !fifo_full;
  assign ep_dataout = ep_q;
  assign trigger    = trigger_q;
  assign done       = done_q;
  assign bad_cmd    = bad_cmd_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: expected words are queued as they are pushed and
// compared on every trigger. Timeout checks follow SPI_SEQ_TIMEOUT_EN.
module tb_spi_cmd_sequencer;

  localparam int DEPTH = 16;
  localparam int GAP   = 4;
  localparam int TO    = 4096;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, go, flush, hostinterrupt;
  logic [31:0] cmd_data;
  logic        cmd_ready, trigger, busy, done, bad_cmd, timeout;
  logic [31:0] ep_dataout;
  logic [4:0]  fifo_count;

  spi_cmd_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_data      (cmd_data),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .go            (go),
    .flush         (flush),
    .ep_dataout    (ep_dataout),
    .trigger       (trigger),
    .hostinterrupt (hostinterrupt),
    .busy          (busy),
    .done          (done),
    .fifo_count    (fifo_count),
    .bad_cmd       (bad_cmd),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_checks = 0, n_fail = 0;
  int          trig_cnt = 0, done_cnt = 0;
  int          go_cyc = 0, last_trig_cyc = 0, model_cnt = 0;
  bit          spacing_en = 0, last_was_ctrl = 0, first_pending = 0, hi_auto = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every trigger pops the scoreboard; 0 is a sentinel no legal word can match.
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (done) done_cnt++;
    if (trigger) begin
      trig_cnt++;
      exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
      check("ep_dataout", ep_dataout, exp_w);
      if (first_pending) begin
        check("go_to_trigger", cyc - go_cyc, 2);
        first_pending = 0;
      end
      if (spacing_en && last_was_ctrl) check("ctrl_spacing", cyc - last_trig_cyc, GAP + 2);
      last_trig_cyc = cyc;
      last_was_ctrl = (ep_dataout[31:30] == 2'b10);
    end
  end

  // Responder: emulate the SPI master finishing 20 cycles after each DATA trigger.
  initial begin
    hostinterrupt = 1'b0;
    forever begin
      @(negedge clk);
      if (hi_auto && trigger && ep_dataout[31:30] == 2'b01) begin
        repeat (20) @(posedge clk);
        #1 hostinterrupt = 1'b1;
        @(posedge clk);
        #1 hostinterrupt = 1'b0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    cmd_data  = w;
    cmd_valid = 1'b1;
    if (model_cnt < DEPTH) begin
      model_cnt++;
      if (w[31:30] == 2'b10 || w[31:30] == 2'b01) exp_q.push_back(w);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_go();
    go            = 1'b1;
    go_cyc        = cyc;
    last_was_ctrl = 0;
    first_pending = 1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("done_within_bound", 32'(done_cnt - d0), 1);
    model_cnt = 0;
  endtask

  task automatic wait_trigger(input int max_cycles);
    int t0 = trig_cnt;
    int n  = 0;
    while (trig_cnt == t0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("trigger_within_bound", 32'(trig_cnt - t0), 1);
  endtask

  initial begin
    int t0, d0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; go = 1'b0; flush = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_trigger", trigger, 0);
    check("rst_ep_dataout", ep_dataout, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_flags", {done, bad_cmd, timeout}, 0);

    // 1) mixed CTRL/DATA run with master acknowledgements
    hi_auto = 1; spacing_en = 1;
    t0 = trig_cnt; d0 = done_cnt;
    push(32'h8000_0051); push(32'h4000_0001); push(32'h8000_0001); push(32'h4000_8AA5);
    check("t1_fifo_count", fifo_count, 4);
    pulse_go();
    wait_done(500);
    tick(5);
    check("t1_triggers", 32'(trig_cnt - t0), 4);
    check("t1_done_once", 32'(done_cnt - d0), 1);
    check("t1_fifo_empty", fifo_count, 0);
    check("t1_idle", busy, 0);

    // 2) fill to DEPTH, overflow push dropped, replay all in order
    t0 = trig_cnt;
    for (int i = 0; i < DEPTH; i++)
      push((i % 2 == 0) ? 32'h8000_0100 + 32'(i) : 32'h4000_0200 + 32'(i));
    check("t2_full_not_ready", cmd_ready, 0);
    push(32'h8000_0FFF);
    check("t2_count_16", fifo_count, 16);
    pulse_go();
    wait_done(2000);
    tick(2);
    check("t2_triggers", 32'(trig_cnt - t0), 16);

    // 3) reserved word dropped between two CTRL words
    spacing_en = 0;
    t0 = trig_cnt;
    push(32'h8000_0010); push(32'h0000_1234); push(32'h8000_0020);
    pulse_go();
    wait_done(200);
    check("t3_bad_cmd", bad_cmd, 1);
    check("t3_triggers", 32'(trig_cnt - t0), 2);

    // 4) DATA word never acknowledged
    hi_auto = 0;
    t0 = trig_cnt;
    push(32'h4000_3710);
    pulse_go();
    check("t4_go_clears_bad_cmd", bad_cmd, 0);
    tick(300);
    check("t4_triggers", 32'(trig_cnt - t0), 1);
`ifdef SPI_SEQ_TIMEOUT_EN
    wait_done(TO + 100);
    tick();
    check("t4_timeout", timeout, 1);
    check("t4_idle", busy, 0);
`else
    check("t4_still_busy", busy, 1);
    check("t4_no_timeout", timeout, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    check("t4_flush_idle", busy, 0);
`endif

    // 5) flush during WAIT_DONE, with a simultaneous push that must lose
    push(32'h4000_0A01); push(32'h4000_0A02); push(32'h4000_0A03);
    pulse_go();
    wait_trigger(20);
    tick(GAP);
    check("t5_in_wait", busy, 1);
    flush = 1'b1; cmd_valid = 1'b1; cmd_data = 32'h8000_0099;
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    exp_q.delete(); model_cnt = 0;
    check("t5_idle", busy, 0);
    check("t5_fifo_empty", fifo_count, 0);
    t0 = trig_cnt; d0 = done_cnt;
    tick(30);
    check("t5_no_trigger", 32'(trig_cnt - t0), 0);
    check("t5_no_done", 32'(done_cnt - d0), 0);

    // 6) rst during GAP, then go on an empty FIFO
    push(32'h8000_0011); push(32'h8000_0022);
    pulse_go();
    wait_trigger(20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete(); model_cnt = 0;
    check("t6_busy", busy, 0);
    check("t6_trigger", trigger, 0);
    check("t6_ep_dataout", ep_dataout, 0);
    check("t6_fifo_count", fifo_count, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    check("t6_flags", {done, bad_cmd, timeout}, 0);
    t0 = trig_cnt;
    pulse_go();
    check("t6_done_not_yet", done, 0);
    tick();
    check("t6_done_pulse", done, 1);
    tick();
    check("t6_done_1cycle", done, 0);
    check("t6_no_trigger", 32'(trig_cnt - t0), 0);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
